// File: rtl/matrix_in_decoder_if.sv
// Bus bundle for matrix_in_decoder: the four LED-driver serial pins it samples
// plus everything it reports about the decoded command stream.
interface matrix_in_decoder_if #(
  parameter int IDX_W = 9
);
  logic             sdi;
  logic             dclk;
  logic             le;
  logic             gclk;
  logic             cmd_valid;
  logic [2:0]       cmd;
  logic [15:0]      word;
  logic [IDX_W-1:0] data_index;
  logic [15:0]      cfg1;
  logic [15:0]      cfg2;
  logic             outputs_en;
  logic [15:0]      frame_count;
  logic [4:0]       row_index;
  logic             err;

  modport master (
    output sdi, dclk, le, gclk,
    input  cmd_valid, cmd, word, data_index, cfg1, cfg2,
           outputs_en, frame_count, row_index, err
  );

  modport slave (
    input  sdi, dclk, le, gclk,
    output cmd_valid, cmd, word, data_index, cfg1, cfg2,
           outputs_en, frame_count, row_index, err
  );
endinterface

// File: rtl/matrix_in_decoder.sv
// Passive LED-driver bus receiver: classifies latch pulses by dclk count and
// tracks config/enable/frame state. Define MATRIX_IN_GCLK_TRACK_EN for row tracking.
module matrix_in_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = 9
) (
  input logic                clk,
  input logic                rst_n,
  matrix_in_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    CMD_DATA    = 3'd0,
    CMD_VSYNC   = 3'd1,
    CMD_CFG1    = 3'd2,
    CMD_CFG2    = 3'd3,
    CMD_ENABLE  = 3'd4,
    CMD_PREACT  = 3'd5,
    CMD_UNKNOWN = 3'd7
  } cmd_e;

  localparam int SIG_SDI  = 0;
  localparam int SIG_DCLK = 1;
  localparam int SIG_LE   = 2;

`ifdef MATRIX_IN_GCLK_TRACK_EN
  localparam int NSIG = 4;
  localparam int SIG_GCLK = 3;
  logic [NSIG-1:0] w_pin;
  assign w_pin = {bus.gclk, bus.le, bus.dclk, bus.sdi};
`else
  localparam int NSIG = 3;
  logic [NSIG-1:0] w_pin;
  logic            w_unused_gclk;
  assign w_pin         = {bus.le, bus.dclk, bus.sdi};
  assign w_unused_gclk = bus.gclk;
`endif

  logic [NSIG-1:0] r_sync [SYNC_STAGES];
  logic [NSIG-1:0] r_prev;
  logic [NSIG-1:0] w_s;

  // NOTE: every flop, synchronizer chain included, takes the async reset so a
  // reset in the middle of a word leaves no stale bits behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= w_pin;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  logic        w_dclk_rise;
  logic        w_le_fall;
  logic        w_lcnt_inc;
  logic [15:0] w_sh_next;
  logic [3:0]  w_lcnt_next;
  logic        w_decode;
  cmd_e        w_cmd;

  assign w_dclk_rise = w_s[SIG_DCLK] & ~r_prev[SIG_DCLK];
  assign w_le_fall   = ~w_s[SIG_LE] & r_prev[SIG_LE];
  // A dclk rise on the same sample as the le fall still counts as latched.
  assign w_lcnt_inc  = w_dclk_rise & (w_s[SIG_LE] | r_prev[SIG_LE]);

  logic [15:0] r_sh;
  logic [3:0]  r_lcnt;

  assign w_sh_next   = w_dclk_rise ? {r_sh[14:0], w_s[SIG_SDI]} : r_sh;
  assign w_lcnt_next = (w_lcnt_inc && (r_lcnt != 4'd15)) ? r_lcnt + 4'd1 : r_lcnt;
  assign w_decode    = w_le_fall && (w_lcnt_next != 4'd0);

  // NOTE: assign the default first so no latch is inferred for unlisted counts.
  always_comb begin
    w_cmd = CMD_UNKNOWN;
    case (w_lcnt_next)
      4'd1:    w_cmd = CMD_DATA;
      4'd3:    w_cmd = CMD_VSYNC;
      4'd4:    w_cmd = CMD_CFG1;
      4'd6:    w_cmd = CMD_CFG2;
      4'd12:   w_cmd = CMD_ENABLE;
      4'd14:   w_cmd = CMD_PREACT;
      default: w_cmd = CMD_UNKNOWN;
    endcase
  end

  logic             r_armed;
  logic             r_cmd_valid;
  cmd_e             r_cmd;
  logic [15:0]      r_word;
  logic [IDX_W-1:0] r_data_index;
  logic [15:0]      r_cfg1;
  logic [15:0]      r_cfg2;
  logic             r_outputs_en;
  logic [15:0]      r_frame_count;
  logic             r_err;

  // NOTE: non-blocking assignments throughout so every register sees the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh          <= '0;
      r_lcnt        <= '0;
      r_armed       <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd         <= CMD_DATA;
      r_word        <= '0;
      r_data_index  <= '0;
      r_cfg1        <= '0;
      r_cfg2        <= '0;
      r_outputs_en  <= 1'b0;
      r_frame_count <= '0;
      r_err         <= 1'b0;
    end else begin
      r_sh        <= w_sh_next;
      r_lcnt      <= w_le_fall ? 4'd0 : w_lcnt_next;
      r_cmd_valid <= 1'b0;
      r_err       <= 1'b0;
      if (w_decode) begin
        r_cmd_valid <= 1'b1;
        r_cmd       <= w_cmd;
        r_word      <= w_sh_next;
        r_armed     <= (w_cmd == CMD_PREACT);
        case (w_cmd)
          CMD_DATA:   r_data_index <= r_data_index + IDX_W'(1);
          CMD_VSYNC: begin
            r_frame_count <= r_frame_count + 16'd1;
            r_data_index  <= '0;
          end
          CMD_CFG1:   if (r_armed) r_cfg1 <= w_sh_next; else r_err <= 1'b1;
          CMD_CFG2:   if (r_armed) r_cfg2 <= w_sh_next; else r_err <= 1'b1;
          CMD_ENABLE: if (r_armed) r_outputs_en <= 1'b1; else r_err <= 1'b1;
          CMD_PREACT: ;
          default:    r_err <= 1'b1;
        endcase
      end
    end
  end

`ifdef MATRIX_IN_GCLK_TRACK_EN
  localparam logic [7:0] GCLK_LAST = 8'd137;

  logic       w_gclk_rise;
  logic       w_vsync;
  logic [7:0] r_gcnt;
  logic [4:0] r_row;

  assign w_gclk_rise = w_s[SIG_GCLK] & ~r_prev[SIG_GCLK];
  assign w_vsync     = w_decode && (w_cmd == CMD_VSYNC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gcnt <= '0;
      r_row  <= '0;
    end else if (w_vsync) begin
      r_gcnt <= '0;
      r_row  <= '0;
    end else if (w_gclk_rise) begin
      if (r_gcnt == GCLK_LAST) begin
        r_gcnt <= '0;
        r_row  <= (r_row == r_cfg1[12:8]) ? 5'd0 : r_row + 5'd1;
      end else begin
        r_gcnt <= r_gcnt + 8'd1;
      end
    end
  end

  assign bus.row_index = r_row;
`else
  assign bus.row_index = '0;
`endif

  assign bus.cmd_valid   = r_cmd_valid;
  assign bus.cmd         = r_cmd;
  assign bus.word        = r_word;
  assign bus.data_index  = r_data_index;
  assign bus.cfg1        = r_cfg1;
  assign bus.cfg2        = r_cfg2;
  assign bus.outputs_en  = r_outputs_en;
  assign bus.frame_count = r_frame_count;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_matrix_in_decoder.sv
// Self-checking bench for matrix_in_decoder: bit-level bus driver, behavioural
// command model with an expectation queue, and a per-cycle compare process.
module tb_matrix_in_decoder;
  localparam int SYNC_STAGES = 2;
  localparam int IDX_W       = 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_in_decoder_if #(.IDX_W(IDX_W)) bus ();

  matrix_in_decoder #(.SYNC_STAGES(SYNC_STAGES), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0]       cmd;
    logic [15:0]      word;
    logic             err;
    logic [15:0]      cfg1;
    logic [15:0]      cfg2;
    logic             en;
    logic [15:0]      frame;
    logic [IDX_W-1:0] didx;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t a;
    a.cmd   = bus.cmd;
    a.word  = bus.word;
    a.err   = bus.err;
    a.cfg1  = bus.cfg1;
    a.cfg2  = bus.cfg2;
    a.en    = bus.outputs_en;
    a.frame = bus.frame_count;
    a.didx  = bus.data_index;
    return a;
  endfunction

  // Behavioural model state: every bit ever shifted, arm flag, register file.
  logic [31:0] m_hist;
  bit          m_armed;
  exp_t        m_st;
  exp_t        exp_q[$];

  int n_strobe = 0;
  int n_err    = 0;

  function automatic logic [2:0] classify(input int n);
    int lc;
    lc = (n > 15) ? 15 : n;
    case (lc)
      1:       return 3'd0;
      3:       return 3'd1;
      4:       return 3'd2;
      6:       return 3'd3;
      12:      return 3'd4;
      14:      return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  task automatic model_decode(input int n);
    exp_t e;
    bit   prior;
    if (n == 0) return;
    e      = m_st;
    e.cmd  = classify(n);
    e.word = m_hist[15:0];
    e.err  = 1'b0;
    prior  = m_armed;
    m_armed = (e.cmd == 3'd5);
    case (e.cmd)
      3'd0: e.didx = IDX_W'((int'(e.didx) + 1) % (1 << IDX_W));
      3'd1: begin e.frame = e.frame + 16'd1; e.didx = '0; end
      3'd2: if (prior) e.cfg1 = e.word; else e.err = 1'b1;
      3'd3: if (prior) e.cfg2 = e.word; else e.err = 1'b1;
      3'd4: if (prior) e.en = 1'b1; else e.err = 1'b1;
      3'd5: ;
      default: e.err = 1'b1;
    endcase
    exp_q.push_back(e);
    m_st = e;
    m_st.err = 1'b0;
  endtask

  // Compare process: strobe cycles pop the queue, all other cycles must hold state.
  initial begin
    exp_t cur;
    exp_t e;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur = '0;
      end else if (bus.cmd_valid) begin
        n_strobe++;
        if (bus.err) n_err++;
        if (exp_q.size() == 0) begin
          check("spurious_cmd_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_fields", snap(), e);
          cur = e;
          cur.err = 1'b0;
        end
      end else begin
        check("idle_state", snap(), cur);
      end
`ifndef MATRIX_IN_GCLK_TRACK_EN
      if (rst_n) check("row_tied_zero", bus.row_index, 0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit d, input bit l, input bit s);
    bus.dclk = d;
    bus.le   = l;
    bus.sdi  = s;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
    check("strobe_arrived", exp_q.size(), 0);
  endtask

  // Shift nbits of val MSB first; le covers the last n bits. With coincide the
  // le fall lands on the same sample as the final dclk rise.
  task automatic send_bits(input int n, input int nbits, input logic [31:0] val, input bit coincide);
    for (int i = nbits - 1; i >= 0; i--) begin
      bit b;
      bit lat;
      b   = val[i];
      lat = (i < n);
      drive(1'b0, lat, b);
      cyc();
      drive(1'b1, (coincide && i == 0) ? 1'b0 : lat, b);
      cyc();
      m_hist = {m_hist[30:0], b};
    end
    drive(1'b0, 1'b0, 1'b0);
    model_decode(n);
    repeat (6) cyc();
    wait_drain();
  endtask

  task automatic send(input int n, input logic [31:0] val, input bit coincide);
    send_bits(n, (n > 16) ? n : 16, val, coincide);
  endtask

  task automatic pulse_gclk(input int k);
    repeat (k) begin
      bus.gclk = 1'b1;
      cyc();
      bus.gclk = 1'b0;
      cyc();
    end
  endtask

  int lens[12] = '{1, 1, 1, 3, 4, 6, 12, 14, 2, 5, 9, 20};

  initial begin
    int s0, e0;
    m_hist = '0;
    m_armed = 1'b0;
    m_st = '0;
    bus.sdi = 1'b0; bus.dclk = 1'b0; bus.le = 1'b0; bus.gclk = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    check("reset_state", {snap(), bus.row_index}, 0);

    // Armed cfg1 write.
    e0 = n_err;
    send(14, $urandom, 1'b0);
    send(4, 32'h0000_0370, 1'b0);
    check("cfg1_armed", bus.cfg1, 16'h0370);
    check("cfg1_cmd", bus.cmd, 3'd2);
    check("cfg1_no_err", n_err - e0, 0);

    // Armed cfg2 and enable.
    send(14, $urandom, 1'b0);
    send(6, 32'h0000_7FFF, 1'b0);
    send(14, $urandom, 1'b1);
    send(12, $urandom, 1'b0);
    check("cfg2_armed", bus.cfg2, 16'h7FFF);
    check("outputs_en_set", bus.outputs_en, 1'b1);

    // Unarmed cfg1.
    e0 = n_err; s0 = n_strobe;
    send(4, 32'h0000_1234, 1'b0);
    check("unarmed_err_pulse", n_err - e0, 1);
    check("unarmed_strobe", n_strobe - s0, 1);
    check("cfg1_unchanged", bus.cfg1, 16'h0370);

    // 48 data words then vsync.
    s0 = n_strobe;
    for (int i = 0; i < 47; i++) send(1, $urandom, i[0]);
    send(1, 32'h0000_ABCD, 1'b0);
    check("data_word_last", bus.word, 16'hABCD);
    check("data_index_48", bus.data_index, 48);
    send(3, $urandom, 1'b0);
    check("data_strobes", n_strobe - s0, 49);
    check("vsync_index_zero", bus.data_index, 0);
    check("frame_one", bus.frame_count, 1);

    // Unknown count, and an le pulse with no dclk.
    e0 = n_err;
    send(5, $urandom, 1'b0);
    check("unknown_cmd", bus.cmd, 3'd7);
    check("unknown_err", n_err - e0, 1);
    s0 = n_strobe;
    bus.le = 1'b1;
    repeat (4) cyc();
    bus.le = 1'b0;
    repeat (8) cyc();
    check("bare_le_no_strobe", n_strobe - s0, 0);

`ifdef MATRIX_IN_GCLK_TRACK_EN
    send(3, $urandom, 1'b0);
    check("row_start", bus.row_index, 0);
    pulse_gclk(137); repeat (4) cyc();
    check("row_after_137", bus.row_index, 0);
    pulse_gclk(1);   repeat (4) cyc();
    check("row_after_138", bus.row_index, 1);
    pulse_gclk(138); repeat (4) cyc();
    check("row_after_276", bus.row_index, 2);
    pulse_gclk(138); repeat (4) cyc();
    check("row_after_414", bus.row_index, 3);
    pulse_gclk(138); repeat (4) cyc();
    check("row_wrap_552", bus.row_index, 0);
    pulse_gclk(138); repeat (4) cyc();
    check("row_again", bus.row_index, 1);
    send(3, $urandom, 1'b0);
    check("row_vsync_restart", bus.row_index, 0);
`else
    pulse_gclk(300); repeat (4) cyc();
    check("row_ignored", bus.row_index, 0);
`endif

    // data_index wrap at 2^IDX_W, using single-bit data transfers.
    send(3, $urandom, 1'b0);
    for (int i = 0; i < 511; i++) send_bits(1, 1, $urandom, 1'b0);
    check("data_index_511", bus.data_index, 511);
    send_bits(1, 1, $urandom, 1'b1);
    check("data_index_wrap", bus.data_index, 0);
    send_bits(1, 1, $urandom, 1'b0);
    check("data_index_after_wrap", bus.data_index, 1);

    // Random command stream, including saturating and coincident latches.
    for (int k = 0; k < 150; k++) begin
      send(lens[$urandom_range(0, 11)], $urandom, bit'($urandom_range(0, 1)));
    end

    // Reset asserted mid-word with le high.
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, bit'($urandom_range(0, 1)));
      cyc();
      bus.dclk = 1'b1;
      cyc();
    end
    check("pre_reset_frame_nonzero", bus.frame_count != 16'd0, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {snap(), bus.cmd_valid, bus.row_index}, 0);
    m_hist = '0;
    m_armed = 1'b0;
    m_st = '0;
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    check("post_reset_state", {snap(), bus.row_index}, 0);
    e0 = n_err;
    send(4, 32'h0000_00FF, 1'b0);
    check("post_reset_unarmed", n_err - e0, 1);
    send(14, $urandom, 1'b0);
    send(4, 32'h0000_0A5A, 1'b0);
    check("post_reset_cfg1", bus.cfg1, 16'h0A5A);

    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_in_decoder.md
# matrix_in_decoder

Passive receiver for the LED-driver serial bus that `matrix_out` drives. It samples `sdi`/`dclk`/`le`/`gclk` and classifies each latch pulse by its `dclk` count. It reports each decoded command with the last 16 shifted bits, tracks the configuration registers, output-enable state, frames and current scan row. It serves as the bench model of the far end of the chain and as an on-chip bus monitor.

## Interface
- `SYNC_STAGES`, 2: input synchronizer depth (1..3).
- `IDX_W`, 9: width of `data_index`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sdi`  in  1  serial data, MSB first.
- `dclk`  in  1  data clock; bits captured on rising edge.
- `le`  in  1  latch enable.
- `gclk`  in  1  grayscale clock.
- `cmd_valid`  out  1  one-cycle strobe per decoded latch pulse.
- `cmd`  out  3  command code: 0 data, 1 vsync, 2 cfg1, 3 cfg2, 4 enable, 5 preactivate, 7 unknown.
- `word`  out  16  last 16 bits shifted before the latch pulse ended.
- `data_index`  out  IDX_W  number of data latches since last vsync.
- `cfg1`, `cfg2`  out  16  committed config registers.
- `outputs_en`  out  1  set by enable command.
- `frame_count`  out  16  vsync count.
- `row_index`  out  5  current scan row.
- `err`  out  1  one-cycle strobe on unknown or unarmed config command.

## Operation
- Inputs pass through `SYNC_STAGES` flops, then a 1-flop edge detector.
- Each sampled `dclk` rise:
  - Shift `sdi` into the 16-bit register: `sh <= {sh[14:0], sdi}`.
  - If `le` is sampled high in the same cycle, increment `lcnt`. `lcnt` is a 4-bit counter that saturates at 15.
- Sampled `le` fall:
  - If `lcnt == 0`, ignore the fall and raise no strobe.
  - Otherwise classify `lcnt` and decode the command:
    - 1 → data.
    - 3 → vsync.
    - 4 → cfg1.
    - 6 → cfg2.
    - 12 → enable.
    - 14 → preactivate.
    - Any other count → unknown.
  - After decoding, clear `lcnt`.
  - `word <= sh`. When a `dclk` rise coincides with the `le` fall, that bit is included in `word` and in `lcnt`.
- Arm flag:
  - Preactivate sets `armed`.
  - The next decoded command of any type clears `armed`.
- cfg1/cfg2:
  - If `armed`, commit `word`.
  - If not armed, leave the register unchanged and pulse `err`.
  - `cmd_valid` pulses in both cases.
- Enable: `outputs_en <= 1`, only if armed; otherwise pulse `err`.
- Data: `data_index` increments and wraps at 2^IDX_W. `word` holds pixel data.
- Vsync:
  - `frame_count` increments and wraps at 0xFFFF.
  - `data_index <= 0`.
  - Row tracking restarts.
- Unknown: `cmd = 7` and `err` pulses.
- Row tracking (see Configuration):
  - Count sampled `gclk` rises.
  - When the count reaches `138` (fixed, for `cfg1[5:4] == 3`), advance `row_index` and zero the count. At count 138 this takes priority over further counting.
  - `row_index` wraps from `cfg1[12:8]` to 0.
  - A vsync takes priority over a simultaneous gclk advance.
- Reset (async, any time) clears all state immediately, including mid-shift and mid-latch:
  - Outputs go to 0, including `cfg1 = 0`, `cfg2 = 0`, `outputs_en = 0` and `row_index = 0`.
  - `armed` is cleared.

## Timing
- Inputs are synchronous to `clk` (driven by `matrix_out`) or held ≥ SYNC_STAGES+1 cycles per level.
- A level lasting 1 cycle is captured when the source is in the same domain.
- `cmd_valid`, `cmd`, `word`, `err` are valid SYNC_STAGES+1 cycles after `le` falls at the pin.
- `cfg1`, `cfg2`, `outputs_en`, `frame_count`, `data_index` update on the same edge as `cmd_valid`.
- `row_index` changes SYNC_STAGES+1 cycles after the 138th `gclk` rise.
- There is no backpressure. Strobes are single-cycle; consecutive commands are at least 4 cycles apart because the protocol requires it.

## Configuration
- `MATRIX_IN_GCLK_TRACK_EN` defined: `gclk` synchronizer, 8-bit gclk counter and `row_index` logic are compiled in.
- Undefined: `gclk` port remains but is ignored, and `row_index` is tied to 0.

## Test plan
- Preactivate (14 latched clocks), then cfg1 word 0x0370 with 4 latched clocks → cmd 5 then cmd 2; `cfg1 = 0x0370`; `err` = 0.
- Preactivate, cfg2 0x7FFF with 6 latched clocks, preactivate, enable (12) → `cfg2 = 0x7FFF`, `outputs_en = 1`.
- cfg1 0x1234 without preceding preactivate → `cmd_valid` with cmd 2, `err` pulse, `cfg1` unchanged at 0x0370.
- 48 data words, last one 0xABCD, each with a single latched clock, then vsync (3) → 48 cmd-0 strobes, final `word = 0xABCD`, `data_index` 48 then 0, `frame_count = 1`.
- Latch pulse of 5 clocks → `cmd = 7`, `err` pulse. `le` pulse with no `dclk` → no strobe.
- With `MATRIX_IN_GCLK_TRACK_EN` defined and `cfg1 = 0x0370`: 552 gclk rises → `row_index` 0,1,2,3,0. Assert `rst_n` low mid-word → all outputs 0 within the same cycle.
